bit_serializer: RTL and testbench

Upstream feeder for the serial "101" pattern detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per enabled cycle on a single-bit stream. The stream drives the detector's 1-bit x input directly. A one-entry holding register lets back-to-back words stream with no idle bit between them.

---
 rtl/ser_pkg.sv | 26 ++
 rtl/ser_hold_reg.sv | 54 +++++
 rtl/bit_serializer.sv | 127 ++++++++++++
 tb/tb_bit_serializer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serial bit stream that feeds the "101" detector.
// Holds the FSM state type, the counter-width helper and the default word
// width / idle level so the detector bench and the serializer agree.
package ser_pkg;

    localparam int unsigned SER_W_DEFAULT        = 8;
    localparam logic        SER_IDLE_BIT_DEFAULT = 1'b0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Ceiling log2 with a floor of 1 so a W=1 counter still has one bit.
    function automatic int unsigned ser_clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register in front of the shifter.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   in_data         parallel word from upstream
//   in_valid        in_data is valid
//   in_ready        register is empty (registered, equals ~hold_vld)
//   take            shifter pulls the held word this cycle
//   hold_data       held word
//   hold_vld        held word is valid
//   hold_vld_nxt_c  next-cycle value of hold_vld (combinational)
module ser_hold_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         take,
    output logic [W-1:0] hold_data,
    output logic         hold_vld,
    output logic         hold_vld_nxt_c
);

    logic         accept_c;
    logic [W-1:0] hold_d;

    // Accept and take are mutually exclusive: in_ready is low while full.
    always_comb begin
        accept_c       = in_valid & in_ready;
        hold_d         = hold_data;
        hold_vld_nxt_c = hold_vld;
        if (accept_c) begin
            hold_d         = in_data;
            hold_vld_nxt_c = 1'b1;
        end else if (take) begin
            hold_vld_nxt_c = 1'b0;
        end
    end

    // in_ready is kept as its own flop so it has no path from in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_vld  <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            hold_data <= hold_d;
            hold_vld  <= hold_vld_nxt_c;
            in_ready  <= ~hold_vld_nxt_c;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the "101" pattern detector.
// Words arrive over a valid/ready handshake into a one-entry hold register
// and are shifted out one bit per out_en cycle on x.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   in_data      parallel word, in_valid / in_ready handshake
//   out_en       downstream advance enable
//   x            serial bit (IDLE_BIT when no word is shifting)
//   x_valid      x carries a data bit
//   x_last       x is the final bit of the current word
//   busy         shifter active or hold register occupied
module bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned W         = SER_W_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = SER_IDLE_BIT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         out_en,
    output logic         x,
    output logic         x_valid,
    output logic         x_last,
    output logic         busy
);

    localparam int unsigned CW = ser_clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    ser_state_t    state_q, state_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          take_c;
    logic [W-1:0]  hold_data;
    logic          hold_vld;
    logic          hold_vld_nxt_c;
    logic          x_d, x_valid_d, x_last_d, busy_d;

    ser_hold_reg #(
        .W(W)
    ) u_hold (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .take           (take_c),
        .hold_data      (hold_data),
        .hold_vld       (hold_vld),
        .hold_vld_nxt_c (hold_vld_nxt_c)
    );

    // Next-state, shifter and next-output logic.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        take_c  = 1'b0;

        case (state_q)
            IDLE: begin
                // out_en does not gate the load; the first bit appears next cycle.
                if (hold_vld) begin
                    sh_d    = hold_data;
                    cnt_d   = '0;
                    take_c  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_en) begin
                    if (cnt_q != LAST_CNT) begin
                        sh_d  = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
                        cnt_d = cnt_q + CW'(1);
                    end else if (hold_vld) begin
                        // Zero-bubble handoff to the next word.
                        sh_d   = hold_data;
                        cnt_d  = '0;
                        take_c = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of the decode of the next state.
        x_valid_d = (state_d == SHIFT);
        x_d       = IDLE_BIT;
        x_last_d  = 1'b0;
        if (state_d == SHIFT) begin
            x_d      = MSB_FIRST ? sh_d[W-1] : sh_d[0];
            x_last_d = (cnt_d == LAST_CNT);
        end
        busy_d = (state_d == SHIFT) | hold_vld_nxt_c;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            x_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            x       <= x_d;
            x_valid <= x_valid_d;
            x_last  <= x_last_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: a W=8 MSB-first instance driven
// from a vector table plus hand sequences, a W=8 LSB-first instance for the
// mid-word reset case, and a W=1 instance.
module tb_bit_serializer;

    logic clk;

    // MSB-first, W=8
    logic       a_rst_n, a_in_valid, a_in_ready, a_out_en;
    logic       a_x, a_x_valid, a_x_last, a_busy;
    logic [7:0] a_in_data;
    // LSB-first, W=8
    logic       b_rst_n, b_in_valid, b_in_ready, b_out_en;
    logic       b_x, b_x_valid, b_x_last, b_busy;
    logic [7:0] b_in_data;
    // W=1
    logic       c_rst_n, c_in_valid, c_in_ready, c_out_en;
    logic       c_x, c_x_valid, c_x_last, c_busy;
    logic [0:0] c_in_data;

    bit_serializer #(.W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst_n(a_rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_en(a_out_en), .x(a_x), .x_valid(a_x_valid),
        .x_last(a_x_last), .busy(a_busy)
    );

    bit_serializer #(.W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_en(b_out_en), .x(b_x), .x_valid(b_x_valid),
        .x_last(b_x_last), .busy(b_busy)
    );

    bit_serializer #(.W(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w1 (
        .clk(clk), .rst_n(c_rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_en(c_out_en), .x(c_x), .x_valid(c_x_valid),
        .x_last(c_x_last), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_en;
        logic       x;
        logic       x_valid;
        logic       x_last;
        logic       in_ready;
        logic       busy;
    } vec_t;

    vec_t       vecs[$];
    int         checks = 0;
    int         failures = 0;

    logic [7:0] bp_w [3];
    logic [7:0] got[$];
    logic [7:0] cur;
    logic       rdy_hist [64];
    int         widx, nvalid, first_v, last_v, l1, acc2;
    logic       acc, done;
    logic       w1_w [4];
    logic       w1_got[$];
    logic       e82 [8];

    task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%b want=%b", nm, idx, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic v, input logic [7:0] d,
                                input logic e, input logic ex, input logic exv,
                                input logic exl, input logic erdy, input logic ebsy);
        vec_t t;
        t.rst_n = r;   t.in_valid = v;  t.in_data = d;   t.out_en = e;
        t.x = ex;      t.x_valid = exv; t.x_last = exl;  t.in_ready = erdy;
        t.busy = ebsy;
        vecs.push_back(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_en = 1'b1;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_en = 1'b1;
        c_rst_n = 1'b0; c_in_valid = 1'b0; c_in_data = 1'b0;  c_out_en = 1'b1;

        //   rst vld data  en   x xv xl rdy busy
        // Reset held two cycles with in_valid high: nothing accepted.
        add(0, 1, 8'hFF, 1,  0, 0, 0, 1, 0);
        add(0, 1, 8'hFF, 1,  0, 0, 0, 1, 0);
        add(1, 0, 8'h00, 1,  0, 0, 0, 1, 0);
        // Single word A5, MSB first: 1 0 1 0 0 1 0 1
        add(1, 1, 8'hA5, 1,  0, 0, 0, 0, 1);
        add(1, 0, 8'h00, 1,  1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  1, 1, 1, 1, 1);
        add(1, 0, 8'h00, 1,  0, 0, 0, 1, 0);
        // Back-to-back 05 then A0, in_valid held: 00000101 10100000
        add(1, 1, 8'h05, 1,  0, 0, 0, 0, 1);
        add(1, 1, 8'hA0, 1,  0, 1, 0, 1, 1);
        add(1, 1, 8'hA0, 1,  0, 1, 0, 0, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 0, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 0, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 0, 1);
        add(1, 0, 8'h00, 1,  1, 1, 0, 0, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 0, 1);
        add(1, 0, 8'h00, 1,  1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1,  1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 1, 1, 1);
        add(1, 0, 8'h00, 1,  0, 0, 0, 1, 0);
        // Stall: load with out_en low (ignored in IDLE), stall 3 cycles after bit 2
        add(1, 1, 8'hA5, 1,  0, 0, 0, 0, 1);
        add(1, 0, 8'h00, 0,  1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1);
        add(1, 0, 8'h00, 1,  1, 1, 1, 1, 1);
        add(1, 0, 8'h00, 1,  0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            a_rst_n    = vecs[i].rst_n;
            a_in_valid = vecs[i].in_valid;
            a_in_data  = vecs[i].in_data;
            a_out_en   = vecs[i].out_en;
            tick();
            chk1("tbl_x",        i, a_x,        vecs[i].x);
            chk1("tbl_x_valid",  i, a_x_valid,  vecs[i].x_valid);
            chk1("tbl_x_last",   i, a_x_last,   vecs[i].x_last);
            chk1("tbl_in_ready", i, a_in_ready, vecs[i].in_ready);
            chk1("tbl_busy",     i, a_busy,     vecs[i].busy);
        end

        // Back-pressure: three words offered continuously with out_en high.
        bp_w[0] = 8'h3C; bp_w[1] = 8'hC3; bp_w[2] = 8'h5A;
        widx = 0; nvalid = 0; first_v = -1; last_v = -1; l1 = -1; acc2 = -1;
        cur = 8'h00; done = 1'b0;
        a_out_en = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (widx < 3) begin
                a_in_valid = 1'b1;
                a_in_data  = bp_w[widx];
            end else begin
                a_in_valid = 1'b0;
                a_in_data  = 8'h00;
            end
            acc = a_in_valid & a_in_ready;
            tick();
            if (acc) begin
                widx++;
                if (widx == 2) acc2 = cyc;
            end
            rdy_hist[cyc] = a_in_ready;
            if (a_x_valid) begin
                cur = {cur[6:0], a_x};
                nvalid++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (a_x_last) begin
                    got.push_back(cur);
                    if (l1 < 0) l1 = cyc;
                end
            end
            if (widx == 3 && got.size() == 3 && !a_busy) begin
                done = 1'b1;
                break;
            end
        end
        a_in_valid = 1'b0;
        chk1("bp_done", 0, done, 1'b1);
        chki("bp_words", got.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) chk8("bp_word", k, got[k], bp_w[k]);
            else chk8("bp_word", k, 8'hxx, bp_w[k]);
        end
        chki("bp_bits", nvalid, 24);
        chki("bp_contig", last_v - first_v + 1, 24);
        if (acc2 >= 0 && acc2 < 64) chk1("bp_rdy_after_acc2", acc2, rdy_hist[acc2], 1'b0);
        else chki("bp_acc2_seen", acc2, 2);
        if (l1 >= 0 && l1 < 63) begin
            chk1("bp_rdy_on_last1",   l1,     rdy_hist[l1],     1'b0);
            chk1("bp_rdy_after_last1", l1 + 1, rdy_hist[l1 + 1], 1'b1);
        end else begin
            chki("bp_last1_seen", l1, 8);
        end

        // LSB first, reset mid-word with a second word waiting in hold.
        e82[0] = 0; e82[1] = 1; e82[2] = 0; e82[3] = 0;
        e82[4] = 0; e82[5] = 0; e82[6] = 0; e82[7] = 1;
        b_rst_n = 1'b1;
        tick();
        b_in_valid = 1'b1; b_in_data = 8'h01;
        tick();
        b_in_valid = 1'b0;
        tick();
        chk1("lsb_first_x",  0, b_x,       1'b1);
        chk1("lsb_first_xv", 0, b_x_valid, 1'b1);
        b_in_valid = 1'b1; b_in_data = 8'hFF;
        tick();
        b_in_valid = 1'b0;
        chk1("lsb_bit2_x", 0, b_x, 1'b0);
        tick();
        chk1("lsb_bit3_x",   0, b_x,        1'b0);
        chk1("lsb_hold_rdy", 0, b_in_ready, 1'b0);
        b_rst_n = 1'b0;
        tick();
        chk1("rst_mid_xv",   0, b_x_valid,  1'b0);
        chk1("rst_mid_x",    0, b_x,        1'b0);
        chk1("rst_mid_xl",   0, b_x_last,   1'b0);
        chk1("rst_mid_rdy",  0, b_in_ready, 1'b1);
        chk1("rst_mid_busy", 0, b_busy,     1'b0);
        b_rst_n = 1'b1;
        tick();
        tick();
        chk1("post_rst_xv",   0, b_x_valid, 1'b0);
        chk1("post_rst_busy", 0, b_busy,    1'b0);
        b_in_valid = 1'b1; b_in_data = 8'h82;
        tick();
        b_in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk1("w82_x",  k, b_x,       e82[k]);
            chk1("w82_xv", k, b_x_valid, 1'b1);
            chk1("w82_xl", k, b_x_last,  (k == 7) ? 1'b1 : 1'b0);
        end
        tick();
        chk1("w82_end_xv", 0, b_x_valid, 1'b0);

        // W=1: every data bit is also the last bit.
        w1_w[0] = 1'b1; w1_w[1] = 1'b0; w1_w[2] = 1'b1; w1_w[3] = 1'b1;
        c_rst_n = 1'b1;
        tick();
        widx = 0; done = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (widx < 4) begin
                c_in_valid = 1'b1;
                c_in_data  = w1_w[widx];
            end else begin
                c_in_valid = 1'b0;
                c_in_data  = 1'b0;
            end
            acc = c_in_valid & c_in_ready;
            tick();
            if (acc) widx++;
            if (c_x_valid) begin
                w1_got.push_back(c_x);
                chk1("w1_last", w1_got.size() - 1, c_x_last, 1'b1);
            end
            if (widx == 4 && w1_got.size() == 4 && !c_busy) begin
                done = 1'b1;
                break;
            end
        end
        c_in_valid = 1'b0;
        chk1("w1_done", 0, done, 1'b1);
        chki("w1_bits", w1_got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < w1_got.size()) chk1("w1_bit", k, w1_got[k], w1_w[k]);
            else chk1("w1_bit", k, 1'bx, w1_w[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
